dmem_cache_ctrl: RTL
====================

Name: dmem_cache_ctrl

Overview:
Direct-mapped, write-through, write-allocate data cache controller. It sits between the pipeline memory stage and a multi-cycle backing data memory. Its jobs:
- Holds the valid/tag/data arrays.
- Sequences refills and write-throughs over a req/ack handshake.
- Stalls the pipeline until each access completes.
- Keeps load hit and miss counters.

Parameters:
SET_SIZE, 3, log2 of number of sets (8 sets by default)
DATA_WIDTH, 32, address/data width; word-addressed, A[1:0] ignored

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
req  in  1  pipeline memory access valid
WE  in  1  1 = store, 0 = load (qualified by req)
A  in  DATA_WIDTH  byte address; index = A[SET_SIZE+1:2], tag = A[DATA_WIDTH-1:SET_SIZE+2]
WD  in  DATA_WIDTH  store data
RD  out  DATA_WIDTH  load data
stall  out  1  pipeline must hold req/WE/A/WD stable while 1
mem_req  out  1  backing memory request
mem_we  out  1  backing memory write
mem_addr  out  DATA_WIDTH  backing memory word address (A with [1:0] forced to 0)
mem_wdata  out  DATA_WIDTH  backing memory write data
mem_rdata  in  DATA_WIDTH  backing memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse from backing memory
hit_cnt  out  32  load hits since reset
miss_cnt  out  32  load misses since reset

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; all valid bits=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; hit_cnt=0; miss_cnt=0.
  - Tag/data arrays are not cleared.
  - stall=0 and RD=0 while in IDLE with req=0.
- hit = valid[index] && tag[index]==A tag. Combinational, IDLE only.
- States: IDLE, REFILL, WRITE.
- mem_req=1 exactly when state is REFILL or WRITE (Moore output). mem_we=1 only in WRITE.
- mem_addr, mem_wdata and mem_we are latched on the edge leaving IDLE and held constant until return to IDLE.
- IDLE, req=1, WE=0, hit:
  - RD = cached data, same cycle; stall=0.
  - hit_cnt+1 at edge; stay IDLE.
- IDLE, req=1, WE=0, miss:
  - stall=1; RD=0.
  - At edge: latch address, miss_cnt+1, go to REFILL.
- REFILL:
  - While mem_ack=0: stall=1.
  - In the mem_ack cycle: RD=mem_rdata and stall=0 (pipeline advances on this edge).
  - At that edge: data[index]=mem_rdata, tag written, valid=1, go to IDLE.
- IDLE, req=1, WE=1:
  - stall=1.
  - At edge: data[index]=WD, tag written, valid=1 (write-allocate, regardless of hit); latch mem_addr and mem_wdata=WD; go to WRITE.
- WRITE:
  - stall=1 until mem_ack.
  - In the mem_ack cycle: stall=0. At that edge: go to IDLE.
- Stores do not change hit_cnt or miss_cnt.
- Latency:
  - Load hit: 0 extra cycles.
  - Load miss: 1 cycle plus memory latency. mem_req rises 1 cycle after the miss is detected; stall falls in the ack cycle.
  - Store: the same as a load miss.
- Backing memory contract:
  - mem_ack only while mem_req=1.
  - mem_ack seen in IDLE is ignored.
  - Any number of wait cycles (≥0 after mem_req rises) is legal.
- IDLE with req=0: no array or state change; stall=0.
- Counters wrap modulo 2^32 (0xFFFFFFFF+1 → 0).
- Reset mid-operation (REFILL or WRITE):
  - Next cycle: IDLE, mem_req=0, stall=0, all lines invalid.
  - The interrupted refill is never written.
  - A late mem_ack after reset is ignored.
- rst has priority over mem_ack in the same cycle.
- Read-after-write to the same address hits with the new data once the store completes.

Test Plan:
1. Reset, then load A=0x100; memory acks on the 3rd mem_req cycle with 0xDEADBEEF.
   - Cycle 0: stall=1.
   - Cycles 1-3: mem_req=1, mem_we=0, mem_addr=0x100.
   - Cycle 3: RD=0xDEADBEEF, stall=0.
   - Then miss_cnt=1.
2. Immediately load 0x100 again → stall=0, RD=0xDEADBEEF in the same cycle, mem_req stays 0, hit_cnt=1.
3. Load 0x120 (index 0, different tag), ack data 0x0000CAFE → miss, refill, RD=0x0000CAFE. A following load of 0x100 misses again (miss_cnt=3).
4. Store WD=0x12345678 to 0x104, ack after 2 cycles.
   - mem_we=1, mem_addr=0x104, mem_wdata=0x12345678.
   - stall drops in the ack cycle.
   - Next: load 0x104 hits with 0x12345678 and no mem_req.
5. Assert rst during REFILL while mem_req=1, then pulse mem_ack one cycle later.
   - mem_req=0, stall=0, ack ignored.
   - Load 0x100 misses (line invalidated) and both counters read 0 before it.
6. Force hit_cnt to 0xFFFFFFFF (via 2^32-1 hits, or a backdoor preload), then one load hit → hit_cnt=0. Also pulse mem_ack in IDLE with req=0 → no state, array or counter change.

Source files
------------

// File: rtl/dmem_cache_ctrl_if.sv
// Pipeline and backing-memory signal bundle for the data cache.
// The controller takes the slave side, its environment the master side.
interface dmem_cache_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  WE;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic [31:0]           hit_cnt;
  logic [31:0]           miss_cnt;

  modport master (
    output req, WE, A, WD, mem_rdata, mem_ack,
    input  RD, stall, mem_req, mem_we,
    input  mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport slave (
    input  req, WE, A, WD, mem_rdata, mem_ack,
    output RD, stall, mem_req, mem_we,
    output mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate data cache controller.
// Stalls the pipeline across refills and write-throughs; counts load hits/misses.
module dmem_cache_ctrl #(
  parameter int SET_SIZE   = 3,
  parameter int DATA_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  dmem_cache_ctrl_if.slave bus
);
  localparam int SETS  = 1 << SET_SIZE;
  localparam int TAG_W = DATA_WIDTH - SET_SIZE - 2;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  state_t state;

  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_arr  [SETS];
  logic [DATA_WIDTH-1:0] data_arr [SETS];

  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [31:0]           hit_q;
  logic [31:0]           miss_q;

  logic [SET_SIZE-1:0]   idx;
  logic [SET_SIZE-1:0]   fill_idx;
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      fill_tag;
  logic [DATA_WIDTH-1:0] word_addr;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd;
  logic                  stall;
  logic                  unused_byte_sel;

  assign idx       = bus.A[SET_SIZE+1:2];
  assign tag       = bus.A[DATA_WIDTH-1:SET_SIZE+2];
  assign word_addr = {bus.A[DATA_WIDTH-1:2], 2'b00};
  assign unused_byte_sel = ^bus.A[1:0];

  // Refill targets the line latched when the miss left IDLE
  assign fill_idx = mem_addr_q[SET_SIZE+1:2];
  assign fill_tag = mem_addr_q[DATA_WIDTH-1:SET_SIZE+2];

  assign hit = (state == IDLE) && valid[idx] &&
               (tag_arr[idx] == tag);

  always_comb begin
    rd    = '0;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.WE)   stall = 1'b1;
          else if (hit) rd    = data_arr[idx];
          else          stall = 1'b1;
        end
      end
      REFILL: begin
        if (bus.mem_ack) rd    = bus.mem_rdata;
        else             stall = 1'b1;
      end
      WRITE: begin
        stall = !bus.mem_ack;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            if (bus.WE) begin
              data_arr[idx] <= bus.WD;
              tag_arr[idx]  <= tag;
              valid[idx]    <= 1'b1;
              mem_req_q     <= 1'b1;
              mem_we_q      <= 1'b1;
              mem_addr_q    <= word_addr;
              mem_wdata_q   <= bus.WD;
              state         <= WRITE;
            end else if (hit) begin
              hit_q <= hit_q + 32'd1;
            end else begin
              miss_q      <= miss_q + 32'd1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= word_addr;
              mem_wdata_q <= bus.WD;
              state       <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            data_arr[fill_idx] <= bus.mem_rdata;
            tag_arr[fill_idx]  <= fill_tag;
            valid[fill_idx]    <= 1'b1;
            mem_req_q          <= 1'b0;
            state              <= IDLE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.RD        = rd;
  assign bus.stall     = stall;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_q;
  assign bus.miss_cnt  = miss_q;
endmodule
